// File: rtl/serial_add_ctrl_if.sv
// Start/operand request and busy/done/result response of the bit-serial adder.
// The master issues operands; the slave (the adder) returns status and result.
interface serial_add_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Sum;
  logic             Cout;

  modport master (
    output start, A, B, Cin,
    input  busy, done, Sum, Cout
  );

  modport slave (
    input  start, A, B, Cin,
    output busy, done, Sum, Cout
  );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full-adder slice reused for WIDTH cycles, result and done in cycle N+WIDTH+1.
// start is ignored while busy; accepted in DONE for back-to-back operation.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  serial_add_ctrl_if.slave  bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           next_state;
  logic             accept;
  logic             last;

  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] res;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;

  logic             s0;
  logic             c0;
  logic             s;
  logic             c1;
  logic             c;

  // Full-adder slice from two half adders; majority carry is the OR of both carries.
  half_adder u_ha0 (.a(sa[0]), .b(sb[0]), .s(s0), .c(c0));
  half_adder u_ha1 (.a(s0),    .b(carry), .s(s),  .c(c1));
  assign c    = c0 | c1;
  assign last = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    bus.busy   = 1'b0;
    bus.done   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept     = 1'b1;
          next_state = RUN;
        end
      end
      RUN: begin
        bus.busy = 1'b1;
        if (last) begin
          next_state = DONE;
        end
      end
      DONE: begin
        bus.done = 1'b1;
        if (bus.start) begin
          accept     = 1'b1;
          next_state = RUN;
        end else begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sa     <= '0;
      sb     <= '0;
      res    <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else if (accept) begin
      sa    <= bus.A;
      sb    <= bus.B;
      carry <= bus.Cin;
      cnt   <= '0;
    end else if (state == RUN) begin
      sa    <= sa >> 1;
      sb    <= sb >> 1;
      res   <= {s, res[WIDTH-1:1]};
      carry <= c;
      if (last) begin
        // Result lands together with the DONE state so it is valid while done=1.
        cnt    <= '0;
        sum_q  <= {s, res[WIDTH-1:1]};
        cout_q <= c;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign bus.Sum  = sum_q;
  assign bus.Cout = cout_q;
endmodule

module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl (WIDTH=8): vector table plus multi-cycle corner sequences.
module tb_serial_add_ctrl;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serial_add_ctrl_if #(.WIDTH(W)) bus ();
  serial_add_ctrl #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int overlap_cnt = 0;
  logic [7:0] last_sum;
  logic       last_cout;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] s;
    logic       co;
  } vec_t;
  vec_t vecs[8];

  always @(negedge clk) begin
    if (bus.done) done_cnt++;
    if (bus.busy && bus.done) overlap_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input logic [7:0] a, input logic [7:0] b,
                         input logic cin, input logic [7:0] es, input logic ec);
    int nbusy;
    bit got;
    bit held;
    nbusy = 0;
    got   = 1'b0;
    held  = 1'b1;
    bus.A = a; bus.B = b; bus.Cin = cin; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    bus.A = 8'($urandom); bus.B = 8'($urandom); bus.Cin = 1'($urandom);
    for (int i = 0; i < 20 && !got; i++) begin
      if (bus.done) begin
        got = 1'b1;
      end else begin
        if (bus.busy) nbusy++;
        if (bus.Sum !== last_sum || bus.Cout !== last_cout) held = 1'b0;
        step();
      end
    end
    check($sformatf("v%0d_done_seen", idx), 32'(got), 32'd1);
    check($sformatf("v%0d_busy_cycles", idx), 32'(nbusy), 32'd8);
    check($sformatf("v%0d_sum_held_in_run", idx), 32'(held), 32'd1);
    check($sformatf("v%0d_sum", idx), 32'(bus.Sum), 32'(es));
    check($sformatf("v%0d_cout", idx), 32'(bus.Cout), 32'(ec));
    last_sum  = es;
    last_cout = ec;
    step();
    check($sformatf("v%0d_done_one_cycle", idx), 32'(bus.done), 32'd0);
  endtask

  initial begin
    int d0;
    int ndone;
    int t0;
    int gap;
    int idle_gap;
    bit got;
    bit held;
    logic [7:0] s1;
    logic [7:0] s2;
    logic [7:0] sg;
    logic       cg;

    vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[5] = '{8'h0F, 8'hF0, 1'b1, 8'h00, 1'b1};
    vecs[6] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0};
    vecs[7] = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0};

    bus.start = 1'b0; bus.A = '0; bus.B = '0; bus.Cin = 1'b0;
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_sum", 32'(bus.Sum), 32'd0);
    check("reset_cout", 32'(bus.Cout), 32'd0);

    // Idle with start low: every output must stay zero.
    for (int i = 0; i < 20; i++) begin
      step();
      check($sformatf("idle_c%0d", i), {21'd0, bus.busy, bus.done, bus.Cout, bus.Sum}, 32'd0);
    end
    last_sum  = 8'h00;
    last_cout = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_vec(i, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].s, vecs[i].co);
    end

    // A start pulse during RUN must be ignored.
    d0 = done_cnt;
    bus.A = 8'h10; bus.B = 8'h20; bus.Cin = 1'b0; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    step();
    bus.A = 8'hAA; bus.B = 8'h55; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    got = 1'b0; held = 1'b1; sg = '0; cg = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (bus.done) begin
        got = 1'b1; sg = bus.Sum; cg = bus.Cout;
      end else begin
        if (bus.Sum !== last_sum) held = 1'b0;
        step();
      end
    end
    repeat (12) step();
    check("ign_done_seen", 32'(got), 32'd1);
    check("ign_sum", 32'(sg), 32'h30);
    check("ign_cout", 32'(cg), 32'd0);
    check("ign_sum_held", 32'(held), 32'd1);
    check("ign_done_pulses", 32'(done_cnt - d0), 32'd1);
    last_sum = 8'h30; last_cout = 1'b0;

    // Back-to-back with start held high; operands change in the first DONE cycle.
    bus.A = 8'h01; bus.B = 8'h02; bus.Cin = 1'b0; bus.start = 1'b1;
    step();
    ndone = 0; t0 = 0; gap = 0; idle_gap = 0; s1 = '0; s2 = '0;
    for (int i = 0; i < 40 && ndone < 2; i++) begin
      if (bus.done) begin
        ndone++;
        if (ndone == 1) begin
          t0 = i; s1 = bus.Sum; bus.A = 8'h03; bus.B = 8'h04;
        end else begin
          gap = i - t0; s2 = bus.Sum; bus.start = 1'b0;
        end
      end else if (!bus.busy) begin
        idle_gap++;
      end
      if (ndone < 2) step();
    end
    bus.start = 1'b0;
    check("b2b_done_count", 32'(ndone), 32'd2);
    check("b2b_sum1", 32'(s1), 32'h03);
    check("b2b_sum2", 32'(s2), 32'h07);
    check("b2b_gap", 32'(gap), 32'd9);
    check("b2b_idle_cycles", 32'(idle_gap), 32'd0);
    step();
    check("b2b_after_idle", {30'd0, bus.busy, bus.done}, 32'd0);

    // Reset in the middle of RUN abandons the operation.
    bus.A = 8'h7F; bus.B = 8'h01; bus.Cin = 1'b0; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mrst_busy", 32'(bus.busy), 32'd0);
    check("mrst_done", 32'(bus.done), 32'd0);
    check("mrst_sum", 32'(bus.Sum), 32'd0);
    check("mrst_cout", 32'(bus.Cout), 32'd0);
    d0 = done_cnt;
    repeat (15) step();
    check("mrst_no_done", 32'(done_cnt - d0), 32'd0);
    last_sum = 8'h00; last_cout = 1'b0;
    run_vec(8, 8'h02, 8'h03, 1'b0, 8'h05, 1'b0);

    check("busy_done_overlap", 32'(overlap_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Bit-serial multi-bit adder controller that time-shares one 1-bit full-adder slice across WIDTH cycles.
- The slice is built from two half_adder instances plus an OR on their carry outputs.
- Operands are captured on a start handshake. The FSM shifts one bit per cycle through the slice, keeps the carry in a register, and presents a registered WIDTH-bit result with a one-cycle done pulse.
- Serves as the area-minimal adder option next to the combinational adders.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- start  input  1  request to begin an addition; sampled only in IDLE or DONE.
- A  input  WIDTH  operand A; captured on the accepted start cycle.
- B  input  WIDTH  operand B; captured on the accepted start cycle.
- Cin  input  1  carry-in; captured on the accepted start cycle.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse in DONE.
- Sum  output  WIDTH  registered result; holds its value between operations.
- Cout  output  1  registered final carry; holds its value between operations.

Behaviour:
- Reset (synchronous, applies in any state including mid-RUN):
  - state=IDLE.
  - busy=0, done=0, Sum=0, Cout=0.
  - Internal shift registers, carry register and bit counter cleared.
  - Any operation in progress is abandoned; no done pulse is produced for it.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - On start=1, capture A, B, Cin into sa, sb, carry; clear counter; go to RUN.
  - Otherwise stay in IDLE.
- RUN (exactly WIDTH cycles):
  - Each cycle the slice computes s = sa[0]^sb[0]^carry and c = majority(sa[0], sb[0], carry).
  - sa and sb shift right by one. s shifts into the MSB of the result shift register. carry <= c. Counter increments.
  - When counter == WIDTH-1, go to DONE.
  - start is ignored in RUN; A, B and Cin may change freely without effect.
- DONE (one cycle):
  - Sum <= result shift register, Cout <= carry. Both are registered on entry to DONE, so they are valid in the same cycle done=1.
  - done=1, busy=0.
  - If start=1 in this cycle, capture new operands and go directly to RUN (back-to-back operation). Otherwise go to IDLE.
- Latency: start accepted at edge N → busy high for cycles N+1..N+WIDTH → done=1 and Sum/Cout valid in cycle N+WIDTH+1.
  - Throughput with back-to-back starts is one result per WIDTH+1 cycles.
- Sum/Cout are never updated during RUN. They hold the previous result until the next DONE.
- Arithmetic: {Cout,Sum} = A + B + Cin, modulo 2^(WIDTH+1). Wrap-around is reported only through Cout.
- busy and done are never high in the same cycle.
- Counter width is clog2(WIDTH) bits (minimum 1). The counter never exceeds WIDTH-1.

Test Plan (WIDTH=8):
- A=0x5A, B=0x3C, Cin=0, start pulse → busy high for 8 cycles; then done=1 with Sum=0x96, Cout=0.
- A=0xFF, B=0x01, Cin=0 → Sum=0x00, Cout=1. Separately, A=0xFF, B=0xFF, Cin=1 → Sum=0xFF, Cout=1.
- Start A=0x10, B=0x20; on RUN cycle 3 pulse start with A=0xAA, B=0x55 → the second start is ignored. Result is Sum=0x30, Cout=0, exactly one done pulse, and Sum unchanged during RUN.
- Hold start=1 continuously with A=0x01, B=0x02 then A=0x03, B=0x04 (operands changed in the DONE cycle) → done pulses 9 cycles apart. Sums are 0x03 then 0x07; busy is low only during the DONE cycles.
- Start A=0x7F, B=0x01, assert rst on RUN cycle 4 → next cycle busy=0, done=0, Sum=0x00, Cout=0, and no done pulse follows.
  - A following start with A=0x02, B=0x03 → Sum=0x05, Cout=0.
- After reset with start held low for 20 cycles → busy=0, done=0, Sum=0x00, Cout=0 throughout.
